// File: rtl/rob_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : rob_mc_if
// Description : Bundle of issue, writeback, lookup and commit signals
//               between the reorder buffer (slave) and its pipeline
//               neighbours (master).
// Revision    : 1.0 - initial release
// ============================================================================
interface rob_mc_if #(
  parameter int DEPTH    = 16,
  parameter int IDX_W    = 4,
  parameter int WORD_W   = 32,
  parameter int RD_W     = 5,
  parameter int ID_W     = 6,
  parameter int N_WB     = 3,
  parameter int COMMIT_W = 2
);
  // control
  logic                       rdy_in;
  logic                       flush_in;
  // allocate
  logic                       issue_en_in;
  logic [RD_W-1:0]            issue_rd_in;
  logic [ID_W-1:0]            issue_id_in;
  // status
  logic                       full_out;
  logic                       empty_out;
  logic [IDX_W-1:0]           tail_out;
  logic [IDX_W-1:0]           head_out;
  logic [IDX_W:0]             count_out;
  // writeback
  logic [N_WB-1:0]            wb_en_in;
  logic [N_WB*IDX_W-1:0]      wb_pos_in;
  logic [N_WB*WORD_W-1:0]     wb_res_in;
  logic [N_WB-1:0]            wb_jump_en_in;
  logic [N_WB*WORD_W-1:0]     wb_jump_a_in;
  // operand lookup
  logic [IDX_W-1:0]           rs1_pos_in;
  logic [IDX_W-1:0]           rs2_pos_in;
  logic                       rs1_stall_out;
  logic                       rs2_stall_out;
  logic [WORD_W-1:0]          rs1_res_out;
  logic [WORD_W-1:0]          rs2_res_out;
  // commit
  logic [COMMIT_W-1:0]        commit_en_out;
  logic [COMMIT_W*IDX_W-1:0]  commit_pos_out;
  logic [COMMIT_W*RD_W-1:0]   commit_rd_out;
  logic [COMMIT_W*ID_W-1:0]   commit_id_out;
  logic [COMMIT_W*WORD_W-1:0] commit_res_out;
  logic [COMMIT_W-1:0]        commit_jump_en_out;
  logic [COMMIT_W*WORD_W-1:0] commit_jump_a_out;

  modport slave (
    input  rdy_in, flush_in, issue_en_in, issue_rd_in, issue_id_in,
    input  wb_en_in, wb_pos_in, wb_res_in, wb_jump_en_in, wb_jump_a_in,
    input  rs1_pos_in, rs2_pos_in,
    output full_out, empty_out, tail_out, head_out, count_out,
    output rs1_stall_out, rs2_stall_out, rs1_res_out, rs2_res_out,
    output commit_en_out, commit_pos_out, commit_rd_out, commit_id_out,
    output commit_res_out, commit_jump_en_out, commit_jump_a_out
  );

  modport master (
    output rdy_in, flush_in, issue_en_in, issue_rd_in, issue_id_in,
    output wb_en_in, wb_pos_in, wb_res_in, wb_jump_en_in, wb_jump_a_in,
    output rs1_pos_in, rs2_pos_in,
    input  full_out, empty_out, tail_out, head_out, count_out,
    input  rs1_stall_out, rs2_stall_out, rs1_res_out, rs2_res_out,
    input  commit_en_out, commit_pos_out, commit_rd_out, commit_id_out,
    input  commit_res_out, commit_jump_en_out, commit_jump_a_out
  );
endinterface
`default_nettype wire

// File: rtl/rob_mc.sv
`default_nettype none
// ============================================================================
// Module      : rob_mc
// Description : Circular reorder buffer. One in-order allocate, N_WB
//               out-of-order writebacks, up to COMMIT_W in-order retires
//               per cycle, two combinational operand-lookup ports.
//               Optional macro ROB_WB_BYPASS_EN: lookups also see the
//               writebacks of the current cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_mc #(
  parameter int DEPTH    = 16,
  parameter int IDX_W    = 4,
  parameter int WORD_W   = 32,
  parameter int RD_W     = 5,
  parameter int ID_W     = 6,
  parameter int N_WB     = 3,
  parameter int COMMIT_W = 2
) (
  input wire      clk_in,
  input wire      rst_in,
  rob_mc_if.slave bus
);

  // pointer / occupancy state
  logic [IDX_W-1:0]  r_head;
  logic [IDX_W-1:0]  r_tail;
  logic [IDX_W:0]    r_count;
  logic [DEPTH-1:0]  r_done;

  // entry payload (not reset: only read once allocated and written back)
  logic [RD_W-1:0]   r_rd    [DEPTH];
  logic [ID_W-1:0]   r_id    [DEPTH];
  logic [WORD_W-1:0] r_res   [DEPTH];
  logic [WORD_W-1:0] r_ja    [DEPTH];
  logic [DEPTH-1:0]  r_jen;

  // registered commit outputs
  logic [COMMIT_W-1:0]        r_cen;
  logic [COMMIT_W*IDX_W-1:0]  r_cpos;
  logic [COMMIT_W*RD_W-1:0]   r_crd;
  logic [COMMIT_W*ID_W-1:0]   r_cid;
  logic [COMMIT_W*WORD_W-1:0] r_cres;
  logic [COMMIT_W-1:0]        r_cjen;
  logic [COMMIT_W*WORD_W-1:0] r_cja;

  logic              w_full;
  logic              w_alloc;
  logic [DEPTH-1:0]  w_occ;
  logic [N_WB-1:0]   w_wb_ok;
  logic [DEPTH-1:0]  w_wb_hit;
  logic [DEPTH-1:0]  w_wb_jen;
  logic [WORD_W-1:0] w_wb_res [DEPTH];
  logic [WORD_W-1:0] w_wb_ja  [DEPTH];
  logic [1:0]        w_ret;
  logic [IDX_W:0]    w_nret;
  logic [IDX_W-1:0]  w_slot_pos [2];
  logic              w_rs1_stall;
  logic              w_rs2_stall;
  logic [WORD_W-1:0] w_rs1_res;
  logic [WORD_W-1:0] w_rs2_res;

  assign w_full  = (r_count == (IDX_W+1)'(DEPTH));
  assign w_alloc = bus.issue_en_in && !w_full;

  // An entry is occupied when its distance from head is below the count.
  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ[i] = ({1'b0, IDX_W'(IDX_W'(i) - r_head)} < r_count);
    end
  end

  // Resolve writebacks per entry; later (higher) ports override earlier ones.
  always_comb begin
    w_wb_ok  = '0;
    w_wb_hit = '0;
    w_wb_jen = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_wb_res[i] = '0;
      w_wb_ja[i]  = '0;
    end
    for (int p = 0; p < N_WB; p++) begin
      w_wb_ok[p] = bus.wb_en_in[p] && w_occ[bus.wb_pos_in[p*IDX_W +: IDX_W]];
    end
    for (int i = 0; i < DEPTH; i++) begin
      for (int p = 0; p < N_WB; p++) begin
        if (w_wb_ok[p] && (bus.wb_pos_in[p*IDX_W +: IDX_W] == IDX_W'(i))) begin
          w_wb_hit[i] = 1'b1;
          w_wb_res[i] = bus.wb_res_in[p*WORD_W +: WORD_W];
          w_wb_jen[i] = bus.wb_jump_en_in[p];
          w_wb_ja[i]  = bus.wb_jump_a_in[p*WORD_W +: WORD_W];
        end
      end
    end
  end

  // Retire selection from registered state; a redirect ends the retire group.
  always_comb begin
    w_slot_pos[0] = r_head;
    w_slot_pos[1] = r_head + IDX_W'(1);
    w_ret[0] = (r_count != '0) && r_done[r_head];
    w_ret[1] = (COMMIT_W == 2) && w_ret[0] && (r_count >= (IDX_W+1)'(2))
               && r_done[w_slot_pos[1]] && !r_jen[r_head];
    w_nret   = (IDX_W+1)'(w_ret[0]) + (IDX_W+1)'(w_ret[1]);
  end

  // Pointers, done bits and commit outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in || (bus.rdy_in && bus.flush_in)) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_done  <= '0;
      r_cen   <= '0;
      r_cpos  <= '0;
      r_crd   <= '0;
      r_cid   <= '0;
      r_cres  <= '0;
      r_cjen  <= '0;
      r_cja   <= '0;
    end else if (bus.rdy_in) begin
      r_head  <= r_head + IDX_W'(w_nret);
      r_tail  <= w_alloc ? r_tail + IDX_W'(1) : r_tail;
      r_count <= r_count + (IDX_W+1)'(w_alloc) - w_nret;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alloc && (r_tail == IDX_W'(i))) begin
          r_done[i] <= 1'b0;
        end else if (w_wb_hit[i]) begin
          r_done[i] <= 1'b1;
        end
      end
      for (int k = 0; k < COMMIT_W; k++) begin
        r_cen[k]                      <= w_ret[k];
        r_cpos[k*IDX_W +: IDX_W]      <= w_ret[k] ? w_slot_pos[k] : '0;
        r_crd[k*RD_W +: RD_W]         <= w_ret[k] ? r_rd[w_slot_pos[k]] : '0;
        r_cid[k*ID_W +: ID_W]         <= w_ret[k] ? r_id[w_slot_pos[k]] : '0;
        r_cres[k*WORD_W +: WORD_W]    <= w_ret[k] ? r_res[w_slot_pos[k]] : '0;
        r_cjen[k]                     <= w_ret[k] ? r_jen[w_slot_pos[k]] : 1'b0;
        r_cja[k*WORD_W +: WORD_W]     <= w_ret[k] ? r_ja[w_slot_pos[k]] : '0;
      end
    end
  end

  // Payload storage: allocate writes rd/id, writeback writes result fields.
  always_ff @(posedge clk_in) begin
    if (!rst_in && bus.rdy_in && !bus.flush_in) begin
      if (w_alloc) begin
        r_rd[r_tail] <= bus.issue_rd_in;
        r_id[r_tail] <= bus.issue_id_in;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wb_hit[i]) begin
          r_res[i] <= w_wb_res[i];
          r_jen[i] <= w_wb_jen[i];
          r_ja[i]  <= w_wb_ja[i];
        end
      end
    end
  end

  // Operand lookups; unoccupied or not-yet-written entries stall.
  always_comb begin
    w_rs1_stall = !(w_occ[bus.rs1_pos_in] && r_done[bus.rs1_pos_in]);
    w_rs2_stall = !(w_occ[bus.rs2_pos_in] && r_done[bus.rs2_pos_in]);
    w_rs1_res   = r_res[bus.rs1_pos_in];
    w_rs2_res   = r_res[bus.rs2_pos_in];
`ifdef ROB_WB_BYPASS_EN
    for (int p = 0; p < N_WB; p++) begin
      if (w_wb_ok[p] && (bus.wb_pos_in[p*IDX_W +: IDX_W] == bus.rs1_pos_in)) begin
        w_rs1_stall = 1'b0;
        w_rs1_res   = bus.wb_res_in[p*WORD_W +: WORD_W];
      end
      if (w_wb_ok[p] && (bus.wb_pos_in[p*IDX_W +: IDX_W] == bus.rs2_pos_in)) begin
        w_rs2_stall = 1'b0;
        w_rs2_res   = bus.wb_res_in[p*WORD_W +: WORD_W];
      end
    end
`endif
  end

  assign bus.full_out           = w_full;
  assign bus.empty_out          = (r_count == '0);
  assign bus.tail_out           = r_tail;
  assign bus.head_out           = r_head;
  assign bus.count_out          = r_count;
  assign bus.rs1_stall_out      = w_rs1_stall;
  assign bus.rs2_stall_out      = w_rs2_stall;
  assign bus.rs1_res_out        = w_rs1_res;
  assign bus.rs2_res_out        = w_rs2_res;
  assign bus.commit_en_out      = r_cen;
  assign bus.commit_pos_out     = r_cpos;
  assign bus.commit_rd_out      = r_crd;
  assign bus.commit_id_out      = r_cid;
  assign bus.commit_res_out     = r_cres;
  assign bus.commit_jump_en_out = r_cjen;
  assign bus.commit_jump_a_out  = r_cja;

endmodule
`default_nettype wire

// File: tb/tb_rob_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_mc
// Description : Self-checking bench for rob_mc (DEPTH=8, N_WB=3, COMMIT_W=2)
//               with a queue-based reference model of the reorder buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_mc;
  localparam int D  = 8;
  localparam int IW = 3;
  localparam int WW = 32;
  localparam int RW = 5;
  localparam int DW = 6;
  localparam int NW = 3;
  localparam int CW = 2;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  rob_mc_if #(.DEPTH(D), .IDX_W(IW), .WORD_W(WW), .RD_W(RW), .ID_W(DW),
              .N_WB(NW), .COMMIT_W(CW)) bus ();

  rob_mc #(.DEPTH(D), .IDX_W(IW), .WORD_W(WW), .RD_W(RW), .ID_W(DW),
           .N_WB(NW), .COMMIT_W(CW)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model: oldest entry at q[0] ----------------
  typedef struct {
    logic [RW-1:0] rd;
    logic [DW-1:0] id;
    logic          done;
    logic [WW-1:0] res;
    logic          jen;
    logic [WW-1:0] ja;
  } ent_t;

  ent_t          q[$];
  int            m_head, m_tail;
  logic [CW-1:0]    m_cen, m_cjen;
  logic [CW*IW-1:0] m_cpos;
  logic [CW*RW-1:0] m_crd;
  logic [CW*DW-1:0] m_cid;
  logic [CW*WW-1:0] m_cres, m_cja;

  task automatic model_clear_commit();
    m_cen = '0; m_cjen = '0; m_cpos = '0; m_crd = '0;
    m_cid = '0; m_cres = '0; m_cja = '0;
  endtask

  task automatic model_step();
    int sz, n, off, pos;
    ent_t e;
    if (rst || (bus.rdy_in && bus.flush_in)) begin
      q.delete(); m_head = 0; m_tail = 0; model_clear_commit();
    end else if (bus.rdy_in) begin
      sz = q.size();
      n  = 0;
      if (sz >= 1 && q[0].done) begin
        n = 1;
        if (sz >= 2 && q[1].done && !q[0].jen) n = 2;
      end
      model_clear_commit();
      for (int k = 0; k < n; k++) begin
        m_cen[k] = 1'b1;
        m_cpos[k*IW +: IW] = IW'((m_head + k) % D);
        m_crd[k*RW +: RW]  = q[k].rd;
        m_cid[k*DW +: DW]  = q[k].id;
        m_cres[k*WW +: WW] = q[k].res;
        m_cjen[k]          = q[k].jen;
        m_cja[k*WW +: WW]  = q[k].ja;
      end
      for (int p = 0; p < NW; p++) begin
        pos = int'(bus.wb_pos_in[p*IW +: IW]);
        off = (pos - m_head + D) % D;
        if (bus.wb_en_in[p] && off < sz) begin
          q[off].done = 1'b1;
          q[off].res  = bus.wb_res_in[p*WW +: WW];
          q[off].jen  = bus.wb_jump_en_in[p];
          q[off].ja   = bus.wb_jump_a_in[p*WW +: WW];
        end
      end
      for (int k = 0; k < n; k++) void'(q.pop_front());
      if (bus.issue_en_in && sz < D) begin
        e.rd = bus.issue_rd_in; e.id = bus.issue_id_in; e.done = 1'b0;
        e.res = '0; e.jen = 1'b0; e.ja = '0;
        q.push_back(e);
        m_tail = (m_tail + 1) % D;
      end
      m_head = (m_head + n) % D;
    end
  endtask

  // Expected lookup result for a given index under the current inputs.
  task automatic model_lookup(input int pos, output logic stall, output logic [WW-1:0] res);
    int off;
    off   = (pos - m_head + D) % D;
    stall = 1'b1;
    res   = '0;
    if (off < q.size() && q[off].done) begin
      stall = 1'b0; res = q[off].res;
    end
`ifdef ROB_WB_BYPASS_EN
    for (int p = 0; p < NW; p++) begin
      if (bus.wb_en_in[p] && off < q.size() && int'(bus.wb_pos_in[p*IW +: IW]) == pos) begin
        stall = 1'b0; res = bus.wb_res_in[p*WW +: WW];
      end
    end
`endif
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    bus.rdy_in = 1'b1; bus.flush_in = 1'b0; bus.issue_en_in = 1'b0;
    bus.issue_rd_in = '0; bus.issue_id_in = '0;
    bus.wb_en_in = '0; bus.wb_pos_in = '0; bus.wb_res_in = '0;
    bus.wb_jump_en_in = '0; bus.wb_jump_a_in = '0;
    bus.rs1_pos_in = '0; bus.rs2_pos_in = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    idle(); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic issue(input int id);
    bus.issue_en_in = 1'b1; bus.issue_rd_in = RW'(id + 1); bus.issue_id_in = DW'(id);
    tick();
    bus.issue_en_in = 1'b0;
  endtask

  task automatic set_wb(input int p, input int pos, input logic [WW-1:0] res,
                        input logic jen, input logic [WW-1:0] ja);
    bus.wb_en_in[p] = 1'b1;
    bus.wb_pos_in[p*IW +: IW] = IW'(pos);
    bus.wb_res_in[p*WW +: WW] = res;
    bus.wb_jump_en_in[p] = jen;
    bus.wb_jump_a_in[p*WW +: WW] = ja;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; idle(); tick(); tick(); rst = 1'b0;
    n_checks++; if (bus.count_out !== 4'd0) begin n_errors++; $display("FAIL reset_count got %0d want 0", bus.count_out); end
    n_checks++; if (bus.head_out !== 3'd0 || bus.tail_out !== 3'd0) begin n_errors++; $display("FAIL reset_ptr got h%0d t%0d want 0/0", bus.head_out, bus.tail_out); end
    n_checks++; if (bus.empty_out !== 1'b1 || bus.full_out !== 1'b0) begin n_errors++; $display("FAIL reset_flags got e%b f%b want e1 f0", bus.empty_out, bus.full_out); end
    n_checks++; if (bus.commit_en_out !== 2'b00 || bus.commit_res_out !== '0) begin n_errors++; $display("FAIL reset_commit got en%b res%h want 0", bus.commit_en_out, bus.commit_res_out); end
  endtask

  task automatic test_fill_full();
    reset_dut();
    for (int i = 0; i < D; i++) issue(i);
    n_checks++; if (bus.full_out !== 1'b1 || bus.count_out !== 4'd8 || bus.tail_out !== 3'd0) begin n_errors++; $display("FAIL fill_full got f%b c%0d t%0d want f1 c8 t0", bus.full_out, bus.count_out, bus.tail_out); end
    issue(9);
    n_checks++; if (bus.count_out !== 4'd8 || bus.head_out !== 3'd0 || bus.tail_out !== 3'd0) begin n_errors++; $display("FAIL issue_when_full got c%0d h%0d t%0d want c8 h0 t0", bus.count_out, bus.head_out, bus.tail_out); end
  endtask

  task automatic test_dual_retire();
    reset_dut();
    issue(10); issue(11);
    set_wb(0, 0, 32'd5, 1'b0, '0); set_wb(1, 1, 32'd7, 1'b0, '0);
    tick(); idle();
    tick();
    n_checks++; if (bus.commit_en_out !== 2'b11 || bus.commit_res_out !== {32'd7, 32'd5}) begin n_errors++; $display("FAIL dual_retire got en%b res%h want en11 res 7/5", bus.commit_en_out, bus.commit_res_out); end
    n_checks++; if (bus.commit_id_out !== {6'd11, 6'd10} || bus.count_out !== 4'd0) begin n_errors++; $display("FAIL dual_retire_id got id%h c%0d want 11/10 c0", bus.commit_id_out, bus.count_out); end
    tick();
    n_checks++; if (bus.commit_en_out !== 2'b00) begin n_errors++; $display("FAIL commit_pulse got en%b want 00", bus.commit_en_out); end
  endtask

  task automatic test_jump_serialise();
    reset_dut();
    issue(1); issue(2);
    set_wb(0, 0, 32'd1, 1'b1, 32'h100); set_wb(1, 1, 32'd2, 1'b0, '0);
    tick(); idle();
    tick();
    n_checks++; if (bus.commit_en_out !== 2'b01 || bus.commit_jump_en_out[0] !== 1'b1 || bus.commit_jump_a_out[31:0] !== 32'h100) begin n_errors++; $display("FAIL jump_slot0 got en%b j%b a%h want en01 j1 a100", bus.commit_en_out, bus.commit_jump_en_out, bus.commit_jump_a_out[31:0]); end
    tick();
    n_checks++; if (bus.commit_en_out !== 2'b01 || bus.commit_pos_out[2:0] !== 3'd1 || bus.commit_res_out[31:0] !== 32'd2) begin n_errors++; $display("FAIL jump_next got en%b pos%0d res%h want en01 pos1 res2", bus.commit_en_out, bus.commit_pos_out[2:0], bus.commit_res_out[31:0]); end
  endtask

  task automatic test_full_retire_alloc();
    reset_dut();
    for (int i = 0; i < D; i++) issue(i);
    set_wb(0, 0, 32'h33, 1'b0, '0);
    tick(); idle();
    bus.issue_en_in = 1'b1; bus.issue_id_in = 6'd20;
    tick(); tick();
    bus.issue_en_in = 1'b0;
    n_checks++; if (bus.count_out !== 4'd8 || bus.head_out !== 3'd1 || bus.tail_out !== 3'd1) begin n_errors++; $display("FAIL full_retire_alloc got c%0d h%0d t%0d want c8 h1 t1", bus.count_out, bus.head_out, bus.tail_out); end
  endtask

  task automatic test_wb_priority();
    logic exp_stall;
    reset_dut();
    for (int i = 0; i < 4; i++) issue(i);
    set_wb(0, 3, 32'hA, 1'b0, '0); set_wb(2, 3, 32'hB, 1'b0, '0);
    bus.rs1_pos_in = 3'd3;
    #1;
`ifdef ROB_WB_BYPASS_EN
    exp_stall = 1'b0;
    n_checks++; if (bus.rs1_res_out !== 32'hB) begin n_errors++; $display("FAIL bypass_res got %h want b", bus.rs1_res_out); end
`else
    exp_stall = 1'b1;
`endif
    n_checks++; if (bus.rs1_stall_out !== exp_stall) begin n_errors++; $display("FAIL wb_same_cycle_stall got %b want %b", bus.rs1_stall_out, exp_stall); end
    tick(); idle(); bus.rs1_pos_in = 3'd3; #1;
    n_checks++; if (bus.rs1_stall_out !== 1'b0 || bus.rs1_res_out !== 32'hB) begin n_errors++; $display("FAIL wb_priority got s%b res%h want s0 res b", bus.rs1_stall_out, bus.rs1_res_out); end
    bus.rs2_pos_in = 3'd5; #1;
    n_checks++; if (bus.rs2_stall_out !== 1'b1) begin n_errors++; $display("FAIL lookup_unoccupied got s%b want 1", bus.rs2_stall_out); end
  endtask

  task automatic test_flush();
    reset_dut();
    for (int i = 0; i < 5; i++) issue(i);
    set_wb(0, 0, 32'h1, 1'b0, '0); tick(); idle();
    bus.flush_in = 1'b1; bus.issue_en_in = 1'b1; set_wb(1, 1, 32'h2, 1'b0, '0);
    tick(); idle();
    n_checks++; if (bus.count_out !== 4'd0 || bus.head_out !== 3'd0 || bus.tail_out !== 3'd0 || bus.commit_en_out !== 2'b00) begin n_errors++; $display("FAIL flush got c%0d h%0d t%0d en%b want all 0", bus.count_out, bus.head_out, bus.tail_out, bus.commit_en_out); end
  endtask

  task automatic test_random();
    logic exp_s;
    logic [WW-1:0] exp_r;
    int sz;
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      idle();
      sz = q.size();
      bus.rdy_in      = ($urandom_range(0, 9) != 0);
      bus.flush_in    = ($urandom_range(0, 60) == 0);
      bus.issue_en_in = ($urandom_range(0, 9) < 6);
      bus.issue_rd_in = RW'($urandom);
      bus.issue_id_in = DW'($urandom);
      for (int p = 0; p < NW; p++) begin
        if ($urandom_range(0, 1) == 1)
          set_wb(p, (m_head + $urandom_range(0, sz)) % D, $urandom,
                 ($urandom_range(0, 4) == 0), $urandom);
      end
      bus.rs1_pos_in = IW'($urandom);
      bus.rs2_pos_in = IW'($urandom);
      #1;
      model_lookup(int'(bus.rs1_pos_in), exp_s, exp_r);
      n_checks++; if (bus.rs1_stall_out !== exp_s || (!exp_s && bus.rs1_res_out !== exp_r)) begin n_errors++; $display("FAIL rnd_rs1 cyc%0d got s%b r%h want s%b r%h", c, bus.rs1_stall_out, bus.rs1_res_out, exp_s, exp_r); end
      model_lookup(int'(bus.rs2_pos_in), exp_s, exp_r);
      n_checks++; if (bus.rs2_stall_out !== exp_s || (!exp_s && bus.rs2_res_out !== exp_r)) begin n_errors++; $display("FAIL rnd_rs2 cyc%0d got s%b r%h want s%b r%h", c, bus.rs2_stall_out, bus.rs2_res_out, exp_s, exp_r); end
      tick();
      n_checks++; if (bus.count_out !== 4'(q.size()) || bus.head_out !== 3'(m_head) || bus.tail_out !== 3'(m_tail)) begin n_errors++; $display("FAIL rnd_state cyc%0d got c%0d h%0d t%0d want c%0d h%0d t%0d", c, bus.count_out, bus.head_out, bus.tail_out, q.size(), m_head, m_tail); end
      n_checks++; if (bus.full_out !== (q.size() == D) || bus.empty_out !== (q.size() == 0)) begin n_errors++; $display("FAIL rnd_flags cyc%0d got f%b e%b want size %0d", c, bus.full_out, bus.empty_out, q.size()); end
      n_checks++; if (bus.commit_en_out !== m_cen || bus.commit_pos_out !== m_cpos || bus.commit_rd_out !== m_crd || bus.commit_id_out !== m_cid) begin n_errors++; $display("FAIL rnd_commit_ctl cyc%0d got en%b pos%h rd%h id%h want en%b pos%h rd%h id%h", c, bus.commit_en_out, bus.commit_pos_out, bus.commit_rd_out, bus.commit_id_out, m_cen, m_cpos, m_crd, m_cid); end
      n_checks++; if (bus.commit_res_out !== m_cres || bus.commit_jump_en_out !== m_cjen || bus.commit_jump_a_out !== m_cja) begin n_errors++; $display("FAIL rnd_commit_data cyc%0d got res%h j%b a%h want res%h j%b a%h", c, bus.commit_res_out, bus.commit_jump_en_out, bus.commit_jump_a_out, m_cres, m_cjen, m_cja); end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_fill_full();
    test_dual_retire();
    test_jump_serialise();
    test_full_retire_alloc();
    test_wb_priority();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
